actuador_clasificador: RTL and testbench
========================================

ACTUADOR_CLASIFICADOR -- requirements
Module: actuador_clasificador

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 4, gate pulse length in cycles (legal range 1..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, dead time between pulses in cycles (legal range 1..15).
REQ-003 SHALL have parameter DEPTH, default 4, result FIFO depth (fixed power of two, 4).
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port y_code  input  2  protocol code from upstream Mealy stage: 00 idle, 01 inspecting, 10 reject, 11 accept.
REQ-007 SHALL have port clear_counts  input  1  synchronous clear of counters and overflow flag.
REQ-008 SHALL have port gate_accept  output  1  accept diverter drive.
REQ-009 SHALL have port gate_reject  output  1  reject diverter drive.
REQ-010 SHALL have port busy  output  1  high whenever the actuator FSM is not IDLE.
REQ-011 SHALL have port fifo_count  output  3  pending results, 0..4.
REQ-012 SHALL have port accept_count  output  8  saturating accepted-part count.
REQ-013 SHALL have port reject_count  output  8  saturating rejected-part count.
REQ-014 SHALL have port overflow  output  1  sticky flag, a result was dropped because the FIFO was full.

Function
REQ-015 SHALL register y_code each cycle into y_prev; an event SHALL be detected in cycle t when y_code is 10 or 11 and y_prev differs from y_code.
REQ-016 SHALL ignore codes 00 and 01 entirely.
REQ-017 SHALL push a detected event, as 1 bit (1 = accept, 0 = reject), into the FIFO at the end of cycle t; fifo_count SHALL reflect the push in cycle t+1.
REQ-018 SHALL, on an event while the FIFO is full and no pop occurs in the same cycle, drop the event and set overflow from cycle t+1 until clear_counts or reset.
REQ-019 SHALL, on a simultaneous push and pop, store the new entry and leave fifo_count unchanged; a push to a full FIFO with a same-cycle pop SHALL succeed.
REQ-020 SHALL increment accept_count or reject_count on every detected event, dropped or not, saturating at 255.
REQ-021 SHALL give clear_counts priority over a same-cycle increment (counter reads 0 next cycle); clear_counts SHALL NOT affect the FIFO or the FSM.
REQ-022 SHALL implement the actuator FSM with states IDLE, PULSE, GAP.
REQ-023 In IDLE with fifo_count > 0, the FSM SHALL pop the head entry and enter PULSE at the next edge.
REQ-024 In PULSE, the FSM SHALL drive the popped entry's gate (accept -> gate_accept, reject -> gate_reject) high for exactly PULSE_CYCLES cycles, then enter GAP.
REQ-025 In GAP, both gates SHALL be low for exactly GAP_CYCLES cycles, then the FSM SHALL enter IDLE.
REQ-026 gate_accept and gate_reject SHALL be registered Moore outputs and SHALL never both be high.
REQ-027 Latency: an event in cycle t into an empty FIFO with the FSM in IDLE SHALL produce a gate high in cycles t+2 .. t+1+PULSE_CYCLES.
REQ-028 Back-to-back entries SHALL be served in FIFO order with one IDLE cycle between GAP and the next PULSE.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 Reset SHALL force FSM = IDLE, y_prev = 00, FIFO empty, all counters = 0, and gate_accept, gate_reject, busy, overflow all = 0, with fifo_count = 0.
REQ-031 Reset asserted mid-PULSE SHALL drop the gate in the same cycle (asynchronous) and discard all pending FIFO entries.

Structure
REQ-032 SHALL place the y_code enum (Y_IDLE, Y_INSPECT, Y_REJECT, Y_ACCEPT) and the actuator state enum in a shared package.
REQ-033 SHALL instantiate the FIFO as sub-module result_fifo (1-bit wide, DEPTH entries, count output).

Verification
REQ-034 Bench SHALL check a single accept: y_code 01,01,11,00 with 11 in cycle 10 -> gate_accept high in cycles 12..15, gate_reject low throughout, accept_count = 1, busy low from cycle 18.
REQ-035 Bench SHALL check FIFO order: reject, accept, reject events 3 cycles apart -> gate pulses reject, accept, reject in order, each 4 cycles long, with 2 GAP cycles plus 1 IDLE cycle between pulses.
REQ-036 Bench SHALL check overflow: 6 events spaced 2 cycles apart during one PULSE -> FIFO saturates at 4, overflow = 1, and event counters total 6.
REQ-037 Bench SHALL check saturation and clear: 260 accept events -> accept_count = 255; clear_counts together with an event -> count = 0 next cycle and the event is still gated.
REQ-038 Bench SHALL check reset mid-pulse: reset in the 2nd PULSE cycle with 2 entries queued -> gates low immediately, fifo_count = 0, and no pulses after release.
REQ-039 Bench SHALL check a held code: y_code held at 10 for 3 cycles -> exactly one event and reject_count = 1.

Source files
------------

// File: rtl/actuador_clasificador_pkg.sv
// Shared types for the sorter actuator: upstream protocol codes, actuator
// FSM states and common widths.
package actuador_clasificador_pkg;

  typedef enum logic [1:0] {
    Y_IDLE    = 2'b00,
    Y_INSPECT = 2'b01,
    Y_REJECT  = 2'b10,
    Y_ACCEPT  = 2'b11
  } y_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10
  } act_state_t;

  localparam int CNT_W   = 8;
  localparam int TIMER_W = 4;

endpackage

// File: rtl/actuador_clasificador_result_fifo.sv
// Small result queue between event detection and the actuator FSM.
// One bit per entry (1 = accept, 0 = reject), combinational head read.
// A push into a full queue is still taken when a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/actuador_clasificador.sv
// Sorter actuator: detects accept/reject decisions from the upstream Mealy
// stage, queues them, and drives one diverter gate per result with a fixed
// pulse followed by a dead-time gap. Keeps saturating per-class counters.
module actuador_clasificador
  import actuador_clasificador_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int DEPTH        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       y_code,
  input  logic             clear_counts,
  output logic             gate_accept,
  output logic             gate_reject,
  output logic             busy,
  output logic [2:0]       fifo_count,
  output logic [CNT_W-1:0] accept_count,
  output logic [CNT_W-1:0] reject_count,
  output logic             overflow
);

  localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]         y_prev;
  logic               event_det;
  logic               event_acc;
  logic               fifo_head;
  logic               fifo_full;
  logic               pop;
  act_state_t         state;
  act_state_t         state_nx;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nx;
  logic               gate_accept_nx;
  logic               gate_reject_nx;

  // A decision is a fresh reject/accept code; a held code counts once.
  assign event_det = ((y_code == Y_REJECT) || (y_code == Y_ACCEPT)) && (y_prev != y_code);
  assign event_acc = (y_code == Y_ACCEPT);
  assign busy      = (state != ST_IDLE);

  // Previous-code register for edge detection on the protocol code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_prev <= Y_IDLE;
    else       y_prev <= y_code;
  end

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (event_det),
    .pop   (pop),
    .din   (event_acc),
    .dout  (fifo_head),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Per-class counters count every decision, including dropped ones; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_count <= '0;
      reject_count <= '0;
    end else if (clear_counts) begin
      accept_count <= '0;
      reject_count <= '0;
    end else if (event_det) begin
      if (event_acc) accept_count <= sat_inc(accept_count);
      else           reject_count <= sat_inc(reject_count);
    end
  end

  // Sticky flag for a decision lost to a full queue with no pop to make room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  overflow <= 1'b0;
    else if (clear_counts)                      overflow <= 1'b0;
    else if (event_det && fifo_full && !pop)    overflow <= 1'b1;
  end

  // Actuator state, phase timer and registered gate drives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      gate_accept <= 1'b0;
      gate_reject <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      gate_accept <= gate_accept_nx;
      gate_reject <= gate_reject_nx;
    end
  end

  // Next-state logic: pop in IDLE, hold the gate for the pulse, then dead time.
  always_comb begin
    state_nx       = state;
    timer_nx       = timer;
    gate_accept_nx = gate_accept;
    gate_reject_nx = gate_reject;
    pop            = 1'b0;
    case (state)
      ST_IDLE: begin
        gate_accept_nx = 1'b0;
        gate_reject_nx = 1'b0;
        if (fifo_count != '0) begin
          pop            = 1'b1;
          state_nx       = ST_PULSE;
          timer_nx       = '0;
          gate_accept_nx = fifo_head;
          gate_reject_nx = !fifo_head;
        end
      end
      ST_PULSE: begin
        if (timer == PULSE_LAST) begin
          state_nx       = ST_GAP;
          timer_nx       = '0;
          gate_accept_nx = 1'b0;
          gate_reject_nx = 1'b0;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      ST_GAP: begin
        gate_accept_nx = 1'b0;
        gate_reject_nx = 1'b0;
        if (timer == GAP_LAST) begin
          state_nx = ST_IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TIMER_W'(1);
        end
      end
      default: begin
        state_nx       = ST_IDLE;
        timer_nx       = '0;
        gate_accept_nx = 1'b0;
        gate_reject_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_actuador_clasificador.sv
// Bench for actuador_clasificador: directed stimulus pushes expected gate
// pulses into a scoreboard queue; a negedge monitor measures each pulse and
// compares it against the queue head. Register outputs are checked inline.
module tb_actuador_clasificador;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] y_code = 2'b00;
  logic       clear_counts = 1'b0;
  logic       gate_accept;
  logic       gate_reject;
  logic       busy;
  logic [2:0] fifo_count;
  logic [7:0] accept_count;
  logic [7:0] reject_count;
  logic       overflow;

  actuador_clasificador #(
    .PULSE_CYCLES (4),
    .GAP_CYCLES   (2),
    .DEPTH        (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .y_code       (y_code),
    .clear_counts (clear_counts),
    .gate_accept  (gate_accept),
    .gate_reject  (gate_reject),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .accept_count (accept_count),
    .reject_count (reject_count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit kind;
    int start;
    int len;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  bit   free_mode = 1'b0;
  int   free_pulses = 0;
  bit   in_pulse = 1'b0;
  bit   p_kind;
  int   p_start;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_pulse(input bit k, input int s, input int l);
    exp_t e;
    e.kind  = k;
    e.start = s;
    e.len   = l;
    sbq.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic go_cycle(input int c);
    while (cyc < c) next();
  endtask

  // Pulse monitor: measures every gate pulse and scores it.
  always @(negedge clk) begin
    chk("gates_exclusive", int'(gate_accept && gate_reject), 0);
    if (!in_pulse && (gate_accept || gate_reject)) begin
      in_pulse = 1'b1;
      p_kind   = gate_accept;
      p_start  = cyc;
    end else if (in_pulse && !gate_accept && !gate_reject) begin
      in_pulse = 1'b0;
      if (free_mode) begin
        free_pulses++;
        chk("burst_pulse_kind", int'(p_kind), 1);
        chk("burst_pulse_len", cyc - p_start, 4);
      end else if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: kind=%0d start=%0d len=%0d, expected no pulse",
                 p_kind, p_start, cyc - p_start);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind", int'(p_kind), int'(mon_e.kind));
        chk("pulse_start", p_start, mon_e.start);
        chk("pulse_len", cyc - p_start, mon_e.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;

    // Reset state
    #1 reset = 1'b1;
    go_cycle(2);
    chk("rst_gate_accept", gate_accept, 0);
    chk("rst_gate_reject", gate_reject, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_accept_count", accept_count, 0);
    chk("rst_reject_count", reject_count, 0);
    chk("rst_overflow", overflow, 0);
    go_cycle(3);
    reset = 1'b0;

    // Single accept: 01,01,11,00 with 11 in cycle 10
    go_cycle(8);  y_code = 2'b01;
    go_cycle(9);  y_code = 2'b01;
    go_cycle(10); y_code = 2'b11;
    expect_pulse(1'b1, 12, 4);
    go_cycle(11); y_code = 2'b00;
    chk("t1_accept_count", accept_count, 1);
    chk("t1_reject_count", reject_count, 0);
    chk("t1_fifo_after_push", fifo_count, 1);
    go_cycle(12);
    chk("t1_fifo_after_pop", fifo_count, 0);
    chk("t1_busy_pulse", busy, 1);
    go_cycle(13);
    chk("t1_gate_accept_mid", gate_accept, 1);
    chk("t1_gate_reject_mid", gate_reject, 0);
    go_cycle(17);
    chk("t1_busy_gap_end", busy, 1);
    go_cycle(18);
    chk("t1_busy_idle", busy, 0);

    // FIFO order: reject, accept, reject, 3 cycles apart
    go_cycle(20); y_code = 2'b10;
    expect_pulse(1'b0, 22, 4);
    expect_pulse(1'b1, 29, 4);
    expect_pulse(1'b0, 36, 4);
    go_cycle(21); y_code = 2'b00;
    go_cycle(23); y_code = 2'b11;
    go_cycle(24); y_code = 2'b00;
    go_cycle(26); y_code = 2'b10;
    go_cycle(27); y_code = 2'b00;
    chk("t2_fifo_two_pending", fifo_count, 2);

    // Overflow: one starter event, clear, then 6 events 2 cycles apart
    go_cycle(50); y_code = 2'b11;
    expect_pulse(1'b1, 52, 4);
    expect_pulse(1'b0, 59, 4);
    expect_pulse(1'b1, 66, 4);
    expect_pulse(1'b0, 73, 4);
    expect_pulse(1'b1, 80, 4);
    expect_pulse(1'b0, 87, 4);
    go_cycle(51); y_code = 2'b00; clear_counts = 1'b1;
    go_cycle(52); clear_counts = 1'b0;
    chk("t3_cleared_accept", accept_count, 0);
    for (int k = 0; k < 6; k++) begin
      go_cycle(52 + 2 * k);
      y_code = (k % 2 == 0) ? 2'b10 : 2'b11;
      if (k == 5) chk("t3_overflow_before_drop", overflow, 0);
      go_cycle(53 + 2 * k);
      y_code = 2'b00;
      if (k == 4) chk("t3_fifo_full", fifo_count, 4);
    end
    chk("t3_fifo_saturated", fifo_count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_accept_count", accept_count, 3);
    chk("t3_reject_count", reject_count, 3);
    go_cycle(95); clear_counts = 1'b1;
    go_cycle(96); clear_counts = 1'b0;
    chk("t3_overflow_cleared", overflow, 0);
    chk("t3_accept_cleared", accept_count, 0);
    chk("t3_reject_cleared", reject_count, 0);

    // Saturation: 260 accept events
    go_cycle(100);
    free_mode = 1'b1;
    for (int i = 0; i < 260; i++) begin
      y_code = 2'b11;
      next();
      y_code = 2'b00;
      next();
      if (i == 253) chk("t4_accept_254", accept_count, 254);
      if (i == 254) chk("t4_accept_255", accept_count, 255);
    end
    chk("t4_accept_saturated", accept_count, 255);
    n = 0;
    while ((busy || fifo_count != 0) && n < 100) begin
      next();
      n++;
    end
    chk("t4_drain_in_time", int'(n < 100), 1);
    next();
    free_mode = 1'b0;
    chk("t4_burst_pulses_seen", int'(free_pulses > 0), 1);

    // Clear together with an event: clear wins, event still gated
    base = cyc;
    y_code = 2'b11;
    clear_counts = 1'b1;
    expect_pulse(1'b1, base + 2, 4);
    next();
    y_code = 2'b00;
    clear_counts = 1'b0;
    chk("t4_clear_priority", accept_count, 0);
    go_cycle(base + 12);

    // Reset mid-pulse with 2 entries queued
    base = cyc;
    y_code = 2'b11;
    expect_pulse(1'b1, base + 2, 1);
    next(); y_code = 2'b10;
    next(); y_code = 2'b11;
    next(); y_code = 2'b00;
    chk("t5_gate_before_reset", gate_accept, 1);
    chk("t5_fifo_before_reset", fifo_count, 2);
    reset = 1'b1;
    #1;
    chk("t5_gate_accept_async", gate_accept, 0);
    chk("t5_gate_reject_async", gate_reject, 0);
    chk("t5_fifo_flushed", fifo_count, 0);
    chk("t5_busy_reset", busy, 0);
    next();
    next();
    reset = 1'b0;
    go_cycle(cyc + 15);
    chk("t5_fifo_after_release", fifo_count, 0);
    chk("t5_busy_after_release", busy, 0);
    chk("t5_accept_after_release", accept_count, 0);

    // Held reject code: exactly one event
    base = cyc;
    y_code = 2'b10;
    expect_pulse(1'b0, base + 2, 4);
    next();
    chk("t6_reject_first", reject_count, 1);
    next();
    chk("t6_reject_held", reject_count, 1);
    next();
    y_code = 2'b00;
    chk("t6_reject_final", reject_count, 1);
    chk("t6_accept_final", accept_count, 0);

    // Drain scoreboard
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      next();
      n++;
    end
    go_cycle(cyc + 5);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
